money_accumulator: RTL and testbench

Parametrised successor to the vending-machine money counter. Edge-detects coin inserts on a 2-bit coin code and accumulates a configurable-width credit. Credit is bounded by a configurable ceiling, with either reject or clamp overflow policy. Adds a spend request/ack/nak handshake and a refund-all pulse, so the vending FSM can debit credit and return change without owning the counter.

---
 rtl/money_pkg.sv | 34 +++
 rtl/coin_edge_detect.sv | 31 +++
 rtl/money_accumulator.sv | 135 +++++++++++++
 tb/tb_money_accumulator.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/money_pkg.sv
// Shared coin codes, default coin values and the code-to-value mapping
// used by the money accumulator and its coin edge detector.
package money_pkg;

    localparam int unsigned COIN_W = 2;

    localparam logic [COIN_W-1:0] COIN_NONE = 2'b00;
    localparam logic [COIN_W-1:0] COIN_1    = 2'b01;
    localparam logic [COIN_W-1:0] COIN_2    = 2'b10;
    localparam logic [COIN_W-1:0] COIN_3    = 2'b11;

    localparam int unsigned COIN1_VAL_DEF = 1;
    localparam int unsigned COIN2_VAL_DEF = 5;
    localparam int unsigned COIN3_VAL_DEF = 10;

    // Value of a coin code; the caller supplies its configured coin values.
    function automatic int unsigned coin_value(
        input logic [COIN_W-1:0] code,
        input int unsigned       v1,
        input int unsigned       v2,
        input int unsigned       v3
    );
        int unsigned val;
        val = 0;
        case (code)
            COIN_1:  val = v1;
            COIN_2:  val = v2;
            COIN_3:  val = v3;
            default: val = 0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/coin_edge_detect.sv
// Flags a coin insert on the 00 -> nonzero transition of the coin code.
// Holding a code, or moving between nonzero codes, produces no new event.
module coin_edge_detect
    import money_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [COIN_W-1:0] coin_in,
    output logic              coin_event,
    output logic [COIN_W-1:0] coin_code
);

    logic [COIN_W-1:0] prev_coin_q;
    logic [COIN_W-1:0] prev_coin_d;

    always_comb begin
        prev_coin_d = coin_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_coin_q <= COIN_NONE;
        end else begin
            prev_coin_q <= prev_coin_d;
        end
    end

    assign coin_event = (coin_in != COIN_NONE) && (prev_coin_q == COIN_NONE);
    assign coin_code  = coin_in;

endmodule

// File: rtl/money_accumulator.sv
// Credit accumulator for the vending machine: coin crediting with a ceiling,
// spend request/ack/nak handshake and refund-all, evaluated refund > spend > coin.
module money_accumulator
    import money_pkg::*;
#(
    parameter int unsigned AMOUNT_W   = 8,
    parameter int unsigned MAX_AMOUNT = 99,
    parameter int unsigned COIN1_VAL  = COIN1_VAL_DEF,
    parameter int unsigned COIN2_VAL  = COIN2_VAL_DEF,
    parameter int unsigned COIN3_VAL  = COIN3_VAL_DEF,
    parameter bit          CLAMP_MODE = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [COIN_W-1:0]   coin_in,
    input  logic                spend_req,
    input  logic [AMOUNT_W-1:0] spend_amount,
    output logic                spend_ack,
    output logic                spend_nak,
    input  logic                refund_req,
    output logic                refund_valid,
    output logic [AMOUNT_W-1:0] refund_amount,
    output logic [AMOUNT_W-1:0] total_amount,
    output logic                coin_accepted,
    output logic                coin_rejected,
    output logic                full
);

    localparam int unsigned SUM_W = AMOUNT_W + 1;
    localparam logic [SUM_W-1:0]    MAX_EXT = SUM_W'(MAX_AMOUNT);
    localparam logic [AMOUNT_W-1:0] MAX_AMT = AMOUNT_W'(MAX_AMOUNT);

    logic              coin_event;
    logic [COIN_W-1:0] coin_code;

    coin_edge_detect u_coin_edge (
        .clk        (clk),
        .reset      (reset),
        .coin_in    (coin_in),
        .coin_event (coin_event),
        .coin_code  (coin_code)
    );

    logic [SUM_W-1:0] coin_val_ext;
    assign coin_val_ext = SUM_W'(coin_value(coin_code, COIN1_VAL, COIN2_VAL, COIN3_VAL));

    logic [AMOUNT_W-1:0] total_q, total_d;
    logic [AMOUNT_W-1:0] refund_amt_q, refund_amt_d;
    logic                spend_ack_q, spend_ack_d;
    logic                spend_nak_q, spend_nak_d;
    logic                refund_valid_q, refund_valid_d;
    logic                coin_acc_q, coin_acc_d;
    logic                coin_rej_q, coin_rej_d;
    logic                full_q, full_d;
    logic [AMOUNT_W-1:0] post_spend;
    logic [SUM_W-1:0]    sum_ext;

    // Next credit and pulses: refund wins outright, otherwise spend then coin.
    always_comb begin
        total_d        = total_q;
        refund_amt_d   = refund_amt_q;
        spend_ack_d    = 1'b0;
        spend_nak_d    = 1'b0;
        refund_valid_d = 1'b0;
        coin_acc_d     = 1'b0;
        coin_rej_d     = 1'b0;
        post_spend     = total_q;
        sum_ext        = '0;

        if (refund_req) begin
            refund_amt_d   = total_q;
            refund_valid_d = 1'b1;
            total_d        = '0;
            spend_nak_d    = spend_req;
            coin_rej_d     = coin_event;
        end else begin
            if (spend_req) begin
                if (spend_amount <= total_q) begin
                    post_spend  = total_q - spend_amount;
                    spend_ack_d = 1'b1;
                end else begin
                    spend_nak_d = 1'b1;
                end
            end
            total_d = post_spend;
            // Sum one bit wider than the credit so an oversized coin cannot wrap.
            sum_ext = {1'b0, post_spend} + coin_val_ext;
            if (coin_event) begin
                if (sum_ext <= MAX_EXT) begin
                    total_d    = AMOUNT_W'(sum_ext);
                    coin_acc_d = 1'b1;
                end else if (CLAMP_MODE) begin
                    total_d    = MAX_AMT;
                    coin_acc_d = 1'b1;
                end else begin
                    coin_rej_d = 1'b1;
                end
            end
        end

        full_d = (total_d == MAX_AMT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            total_q        <= '0;
            refund_amt_q   <= '0;
            spend_ack_q    <= 1'b0;
            spend_nak_q    <= 1'b0;
            refund_valid_q <= 1'b0;
            coin_acc_q     <= 1'b0;
            coin_rej_q     <= 1'b0;
            full_q         <= 1'b0;
        end else begin
            total_q        <= total_d;
            refund_amt_q   <= refund_amt_d;
            spend_ack_q    <= spend_ack_d;
            spend_nak_q    <= spend_nak_d;
            refund_valid_q <= refund_valid_d;
            coin_acc_q     <= coin_acc_d;
            coin_rej_q     <= coin_rej_d;
            full_q         <= full_d;
        end
    end

    assign total_amount  = total_q;
    assign refund_amount = refund_amt_q;
    assign spend_ack     = spend_ack_q;
    assign spend_nak     = spend_nak_q;
    assign refund_valid  = refund_valid_q;
    assign coin_accepted = coin_acc_q;
    assign coin_rejected = coin_rej_q;
    assign full          = full_q;

endmodule

// File: tb/tb_money_accumulator.sv
// Bench for money_accumulator: a reject-mode and a clamp-mode instance share
// stimulus and are checked against a per-cycle arithmetic model of the credit rules.
module tb_money_accumulator;

    logic       clk;
    logic       reset;
    logic [1:0] coin_in;
    logic       spend_req;
    logic [7:0] spend_amount;
    logic       refund_req;

    logic       spend_ack     [2];
    logic       spend_nak     [2];
    logic       refund_valid  [2];
    logic [7:0] refund_amount [2];
    logic [7:0] total_amount  [2];
    logic       coin_accepted [2];
    logic       coin_rejected [2];
    logic       full          [2];

    int n_checks;
    int n_fail;

    // Model state: index 0 = reject mode, index 1 = clamp mode
    int m_total  [2];
    int m_refund [2];
    bit m_ack [2], m_nak [2], m_rv [2], m_acc [2], m_rej [2];
    int m_prev;

    money_accumulator #(.AMOUNT_W(8), .MAX_AMOUNT(99), .COIN1_VAL(1), .COIN2_VAL(5),
                        .COIN3_VAL(10), .CLAMP_MODE(1'b0)) u_dut_reject (
        .clk(clk), .reset(reset), .coin_in(coin_in), .spend_req(spend_req),
        .spend_amount(spend_amount), .spend_ack(spend_ack[0]), .spend_nak(spend_nak[0]),
        .refund_req(refund_req), .refund_valid(refund_valid[0]),
        .refund_amount(refund_amount[0]), .total_amount(total_amount[0]),
        .coin_accepted(coin_accepted[0]), .coin_rejected(coin_rejected[0]), .full(full[0])
    );

    money_accumulator #(.AMOUNT_W(8), .MAX_AMOUNT(99), .COIN1_VAL(1), .COIN2_VAL(5),
                        .COIN3_VAL(10), .CLAMP_MODE(1'b1)) u_dut_clamp (
        .clk(clk), .reset(reset), .coin_in(coin_in), .spend_req(spend_req),
        .spend_amount(spend_amount), .spend_ack(spend_ack[1]), .spend_nak(spend_nak[1]),
        .refund_req(refund_req), .refund_valid(refund_valid[1]),
        .refund_amount(refund_amount[1]), .total_amount(total_amount[1]),
        .coin_accepted(coin_accepted[1]), .coin_rejected(coin_rejected[1]), .full(full[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock: update the model from the current inputs, then sample after the edge.
    task automatic tick();
        bit ev;
        int v;
        int t;
        ev = (coin_in != 2'b00) && (m_prev == 0);
        case (coin_in)
            2'b01:   v = 1;
            2'b10:   v = 5;
            2'b11:   v = 10;
            default: v = 0;
        endcase
        for (int c = 0; c < 2; c++) begin
            m_ack[c] = 0; m_nak[c] = 0; m_rv[c] = 0; m_acc[c] = 0; m_rej[c] = 0;
            if (reset) begin
                m_total[c]  = 0;
                m_refund[c] = 0;
            end else if (refund_req) begin
                m_refund[c] = m_total[c];
                m_rv[c]     = 1;
                m_total[c]  = 0;
                m_nak[c]    = spend_req;
                m_rej[c]    = ev;
            end else begin
                t = m_total[c];
                if (spend_req) begin
                    if (int'(spend_amount) <= t) begin
                        t = t - int'(spend_amount);
                        m_ack[c] = 1;
                    end else begin
                        m_nak[c] = 1;
                    end
                end
                if (ev) begin
                    if (t + v <= 99) begin
                        t = t + v;
                        m_acc[c] = 1;
                    end else if (c == 1) begin
                        t = 99;
                        m_acc[c] = 1;
                    end else begin
                        m_rej[c] = 1;
                    end
                end
                m_total[c] = t;
            end
        end
        m_prev = reset ? 0 : int'(coin_in);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; coin_in = 2'b00; spend_req = 1'b0; spend_amount = 8'd0; refund_req = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic insert(input logic [1:0] code);
        coin_in = code;
        tick();
        coin_in = 2'b00;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        insert(2'b11);
        insert(2'b10);
        reset = 1'b1; coin_in = 2'b01; spend_req = 1'b1; spend_amount = 8'd1; refund_req = 1'b1;
        tick();
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (total_amount[c] !== 8'd0 || refund_amount[c] !== 8'd0)
                begin n_fail++; $display("FAIL reset_values inst%0d: total=%0d refund=%0d expected 0/0", c, total_amount[c], refund_amount[c]); end
            n_checks++;
            if ({spend_ack[c], spend_nak[c], refund_valid[c], coin_accepted[c], coin_rejected[c], full[c]} !== 6'b0)
                begin n_fail++; $display("FAIL reset_pulses inst%0d: got %b expected 000000", c,
                    {spend_ack[c], spend_nak[c], refund_valid[c], coin_accepted[c], coin_rejected[c], full[c]}); end
        end
        idle_inputs();
    endtask

    task automatic test_coin_sequence();
        int acc_count;
        int exp_tot [3] = '{1, 6, 16};
        do_reset();
        acc_count = 0;
        for (int k = 1; k <= 3; k++) begin
            coin_in = 2'(k);
            for (int h = 0; h < 3; h++) begin
                tick();
                if (coin_accepted[0]) acc_count++;
            end
            coin_in = 2'b00;
            tick();
            n_checks++;
            if (int'(total_amount[0]) != exp_tot[k-1])
                begin n_fail++; $display("FAIL coin_seq_total code%0d: got %0d expected %0d", k, total_amount[0], exp_tot[k-1]); end
        end
        n_checks++;
        if (acc_count != 3)
            begin n_fail++; $display("FAIL coin_seq_pulses: got %0d expected 3", acc_count); end
    endtask

    task automatic test_hold();
        int acc_count;
        do_reset();
        acc_count = 0;
        coin_in = 2'b11;
        for (int h = 0; h < 10; h++) begin
            tick();
            if (coin_accepted[1]) acc_count++;
        end
        coin_in = 2'b10;
        tick();
        if (coin_accepted[1]) acc_count++;
        coin_in = 2'b00;
        tick();
        n_checks++;
        if (acc_count != 1 || total_amount[1] !== 8'd10)
            begin n_fail++; $display("FAIL hold_one_event: pulses=%0d total=%0d expected 1/10", acc_count, total_amount[1]); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 9; k++) insert(2'b11);
        insert(2'b10);
        n_checks++;
        if (total_amount[0] !== 8'd95 || total_amount[1] !== 8'd95 || full[0] !== 1'b0)
            begin n_fail++; $display("FAIL overflow_setup: got %0d/%0d full=%b expected 95/95 full=0", total_amount[0], total_amount[1], full[0]); end
        coin_in = 2'b11;
        tick();
        n_checks++;
        if (coin_rejected[0] !== 1'b1 || coin_accepted[0] !== 1'b0 || total_amount[0] !== 8'd95)
            begin n_fail++; $display("FAIL overflow_reject: rej=%b acc=%b total=%0d expected 1/0/95", coin_rejected[0], coin_accepted[0], total_amount[0]); end
        n_checks++;
        if (coin_accepted[1] !== 1'b1 || total_amount[1] !== 8'd99 || full[1] !== 1'b1)
            begin n_fail++; $display("FAIL overflow_clamp: acc=%b total=%0d full=%b expected 1/99/1", coin_accepted[1], total_amount[1], full[1]); end
        coin_in = 2'b00;
        tick();
    endtask

    task automatic test_spend();
        int amts [3] = '{25, 10, 0};
        int exp_tot [3] = '{5, 5, 5};
        bit exp_ack [3] = '{1'b1, 1'b0, 1'b1};
        do_reset();
        for (int k = 0; k < 3; k++) insert(2'b11);
        for (int k = 0; k < 3; k++) begin
            spend_req = 1'b1;
            spend_amount = 8'(amts[k]);
            tick();
            n_checks++;
            if (spend_ack[0] !== exp_ack[k] || spend_nak[0] !== !exp_ack[k] || int'(total_amount[0]) != exp_tot[k])
                begin n_fail++; $display("FAIL spend_%0d: ack=%b nak=%b total=%0d expected %b/%b/%0d", amts[k],
                    spend_ack[0], spend_nak[0], total_amount[0], exp_ack[k], !exp_ack[k], exp_tot[k]); end
        end
        spend_req = 1'b0;
        tick();
        n_checks++;
        if (spend_ack[0] !== 1'b0 || spend_nak[0] !== 1'b0)
            begin n_fail++; $display("FAIL spend_idle: ack=%b nak=%b expected 0/0", spend_ack[0], spend_nak[0]); end
    endtask

    task automatic test_refund();
        do_reset();
        insert(2'b11);
        insert(2'b10);
        insert(2'b01);
        refund_req = 1'b1; coin_in = 2'b01; spend_req = 1'b1; spend_amount = 8'd3;
        tick();
        n_checks++;
        if (refund_valid[0] !== 1'b1 || refund_amount[0] !== 8'd16 || total_amount[0] !== 8'd0)
            begin n_fail++; $display("FAIL refund_main: valid=%b amount=%0d total=%0d expected 1/16/0", refund_valid[0], refund_amount[0], total_amount[0]); end
        n_checks++;
        if (coin_rejected[0] !== 1'b1 || coin_accepted[0] !== 1'b0 || spend_nak[0] !== 1'b1 || spend_ack[0] !== 1'b0)
            begin n_fail++; $display("FAIL refund_losers: rej=%b acc=%b nak=%b ack=%b expected 1/0/1/0",
                coin_rejected[0], coin_accepted[0], spend_nak[0], spend_ack[0]); end
        refund_req = 1'b0; spend_req = 1'b0;
        tick();
        n_checks++;
        if (refund_valid[0] !== 1'b0 || refund_amount[0] !== 8'd16 || coin_accepted[0] !== 1'b0 || total_amount[0] !== 8'd0)
            begin n_fail++; $display("FAIL refund_hold: valid=%b amount=%0d acc=%b total=%0d expected 0/16/0/0",
                refund_valid[0], refund_amount[0], coin_accepted[0], total_amount[0]); end
        coin_in = 2'b00;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        insert(2'b11);
        insert(2'b11);
        insert(2'b10);
        spend_req = 1'b1; spend_amount = 8'd5; coin_in = 2'b11;
        tick();
        n_checks++;
        if (spend_ack[0] !== 1'b1 || coin_accepted[0] !== 1'b1 || total_amount[0] !== 8'd30)
            begin n_fail++; $display("FAIL spend_and_coin: ack=%b acc=%b total=%0d expected 1/1/30", spend_ack[0], coin_accepted[0], total_amount[0]); end
        spend_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (total_amount[0] !== 8'd0 || {spend_ack[0], spend_nak[0], refund_valid[0], coin_accepted[0], coin_rejected[0]} !== 5'b0)
            begin n_fail++; $display("FAIL reset_mid_hold: total=%0d pulses=%b expected 0/00000", total_amount[0],
                {spend_ack[0], spend_nak[0], refund_valid[0], coin_accepted[0], coin_rejected[0]}); end
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (coin_accepted[0] !== 1'b1 || total_amount[0] !== 8'd10)
            begin n_fail++; $display("FAIL post_reset_first: acc=%b total=%0d expected 1/10", coin_accepted[0], total_amount[0]); end
        tick();
        n_checks++;
        if (coin_accepted[0] !== 1'b0 || total_amount[0] !== 8'd10)
            begin n_fail++; $display("FAIL post_reset_hold: acc=%b total=%0d expected 0/10", coin_accepted[0], total_amount[0]); end
        coin_in = 2'b00;
        tick();
    endtask

    task automatic test_random();
        logic [22:0] got, exp;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 2) == 0) coin_in = 2'($urandom_range(0, 3));
            spend_req    = ($urandom_range(0, 3) == 0);
            spend_amount = 8'($urandom_range(0, 40));
            refund_req   = ($urandom_range(0, 15) == 0);
            reset        = ($urandom_range(0, 63) == 0);
            tick();
            for (int c = 0; c < 2; c++) begin
                got = {total_amount[c], refund_amount[c], spend_ack[c], spend_nak[c], refund_valid[c],
                       coin_accepted[c], coin_rejected[c], full[c], 1'b0};
                exp = {8'(m_total[c]), 8'(m_refund[c]), m_ack[c], m_nak[c], m_rv[c],
                       m_acc[c], m_rej[c], (m_total[c] == 99), 1'b0};
                n_checks++;
                if (got !== exp)
                    begin n_fail++; $display("FAIL random cyc%0d inst%0d: got %h expected %h", cyc, c, got, exp); end
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_prev   = 0;
        for (int c = 0; c < 2; c++) begin
            m_total[c] = 0; m_refund[c] = 0;
        end
        idle_inputs();
        test_reset();
        test_coin_sequence();
        test_hold();
        test_overflow();
        test_spend();
        test_refund();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
